// File: rtl/button_event_one_shot.sv
// Turns a debounced button level into one-cycle press/release/long/repeat events.
// Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is defined; otherwise repeat_pulse is 0.
module button_event_one_shot #(
   parameter int LONG_PRESS_CYCLES = 50000000,
   parameter int REPEAT_CYCLES     = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       btn_held,
   output logic [7:0] press_count
);

   localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             w_level;
   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] w_hold_cnt_next;
   logic             r_press_pulse;
   logic             w_press_next;
   logic             r_release_pulse;
   logic             w_release_next;
   logic             r_long_pulse;
   logic             w_long_next;
   logic             r_btn_held;
   logic             w_held_next;
   logic [7:0]       r_press_count;
   logic [7:0]       w_press_count_next;

   // btn_in is asynchronous to clk: two-flop synchroniser before any decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_level = r_sync2;

   always_comb begin
      w_state_next       = r_state;
      w_hold_cnt_next    = r_hold_cnt;
      w_press_next       = 1'b0;
      w_release_next     = 1'b0;
      w_long_next        = 1'b0;
      w_held_next        = r_btn_held;
      w_press_count_next = r_press_count;
      case (r_state)
         ST_IDLE: begin
            if (w_level) begin
               w_state_next       = ST_PRESSED;
               w_press_next       = 1'b1;
               w_held_next        = 1'b1;
               w_press_count_next = r_press_count + 8'd1;
               w_hold_cnt_next    = '0;
            end
         end
         ST_PRESSED: begin
            // Release is tested first so it beats a coincident long threshold.
            if (!w_level) begin
               w_state_next    = ST_IDLE;
               w_release_next  = 1'b1;
               w_held_next     = 1'b0;
               w_hold_cnt_next = '0;
            end else if (r_hold_cnt == LONG_LAST) begin
               w_state_next = ST_LONG;
               w_long_next  = 1'b1;
            end else begin
               w_hold_cnt_next = r_hold_cnt + CNT_W'(1);
            end
         end
         ST_LONG: begin
            if (!w_level) begin
               w_state_next    = ST_IDLE;
               w_release_next  = 1'b1;
               w_held_next     = 1'b0;
               w_hold_cnt_next = '0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_hold_cnt      <= '0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;
         r_btn_held      <= 1'b0;
         r_press_count   <= 8'd0;
      end else begin
         r_state         <= w_state_next;
         r_hold_cnt      <= w_hold_cnt_next;
         r_press_pulse   <= w_press_next;
         r_release_pulse <= w_release_next;
         r_long_pulse    <= w_long_next;
         r_btn_held      <= w_held_next;
         r_press_count   <= w_press_count_next;
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] r_rep_cnt;
   logic [CNT_W-1:0] w_rep_cnt_next;
   logic             r_repeat_pulse;
   logic             w_repeat_next;

   // Outside a held LONG the counter sits at 0, so entry into LONG starts it cleanly.
   always_comb begin
      w_rep_cnt_next = '0;
      w_repeat_next  = 1'b0;
      if ((r_state == ST_LONG) && w_level) begin
         if (r_rep_cnt == REP_LAST) begin
            w_repeat_next = 1'b1;
         end else begin
            w_rep_cnt_next = r_rep_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rep_cnt      <= '0;
         r_repeat_pulse <= 1'b0;
      end else begin
         r_rep_cnt      <= w_rep_cnt_next;
         r_repeat_pulse <= w_repeat_next;
      end
   end

   assign repeat_pulse = r_repeat_pulse;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign press_pulse   = r_press_pulse;
   assign release_pulse = r_release_pulse;
   assign long_pulse    = r_long_pulse;
   assign btn_held      = r_btn_held;
   assign press_count   = r_press_count;

endmodule

// File: tb/tb_button_event_one_shot.sv
// Directed bench for button_event_one_shot with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_one_shot;

   localparam int L = 8;
   localparam int R = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       btn_in;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       btn_held;
   logic [7:0] press_count;

   int         n_checks;
   int         n_errors;
   int         n_viol;
   logic [7:0] exp_count;

   button_event_one_shot #(
      .LONG_PRESS_CYCLES(L),
      .REPEAT_CYCLES    (R)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .btn_held     (btn_held),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Any cycle with more than one event pulse is a violation.
   initial n_viol = 0;
   always @(negedge clk) begin
      if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse)) > 1)
         n_viol = n_viol + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " press"},   int'(press_pulse),   0);
      chk({tag, " release"}, int'(release_pulse), 0);
      chk({tag, " long"},    int'(long_pulse),    0);
      chk({tag, " repeat"},  int'(repeat_pulse),  0);
      chk({tag, " held"},    int'(btn_held),      0);
      chk({tag, " count"},   int'(press_count),   0);
   endtask

   // Raises btn_in for 'hold' sampled edges, then lowers it; checks every cycle.
   // k counts edges from the first sample: press at k=3, release at k=hold+3,
   // long at k=3+L unless the release lands there or earlier, repeats every R after long.
   task automatic run_press(input int hold, input int ncyc);
      int  rel_k;
      int  long_k;
      bit  e_long;
      bit  e_rep;
      string t;
      rel_k  = hold + 3;
      long_k = 3 + L;
      btn_in = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         t      = $sformatf("hold%0d k%0d", hold, k);
         e_long = (rel_k > long_k) && (k == long_k);
         e_rep  = REP_EN && (k > long_k) && (k < rel_k) && (((k - long_k) % R) == 0);
         chk({t, " press"},   int'(press_pulse),   int'(k == 3));
         chk({t, " release"}, int'(release_pulse), int'(k == rel_k));
         chk({t, " long"},    int'(long_pulse),    int'(e_long));
         chk({t, " repeat"},  int'(repeat_pulse),  int'(e_rep));
         chk({t, " held"},    int'(btn_held),      int'((k >= 3) && (k < rel_k)));
         if (k == 3) begin
            exp_count = exp_count + 8'd1;
            chk({t, " count"}, int'(press_count), int'(exp_count));
         end
         if (k == hold) btn_in = 1'b0;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      exp_count = 8'd0;
      rst       = 1'b1;
      btn_in    = 1'b1;

      // Reset with the button already down: outputs stay 0, then a press follows.
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all_zero($sformatf("reset c%0d", i));
      end
      rst = 1'b0;
      step();
      chk("postrst k1 press", int'(press_pulse), 0);
      step();
      chk("postrst k2 press", int'(press_pulse), 0);
      step();
      chk("postrst k3 press", int'(press_pulse), 1);
      chk("postrst k3 held",  int'(btn_held),    1);
      chk("postrst k3 count", int'(press_count), 1);
      exp_count = 8'd1;
      step();
      chk("postrst k4 press", int'(press_pulse), 0);
      btn_in = 1'b0;
      step();
      chk("postrst k5 release", int'(release_pulse), 0);
      step();
      chk("postrst k6 release", int'(release_pulse), 0);
      step();
      chk("postrst k7 release", int'(release_pulse), 1);
      chk("postrst k7 held",    int'(btn_held),      0);
      chk("postrst k7 long",    int'(long_pulse),    0);
      step();
      chk("postrst k8 release", int'(release_pulse), 0);

      // Short, boundary and long holds.
      run_press(5, 12);
      run_press(1, 5);
      run_press(8, 14);
      run_press(9, 14);
      run_press(20, 25);
      run_press(21, 26);

      // Reset mid-press: no release pulse, count cleared.
      btn_in = 1'b1;
      step();
      step();
      step();
      chk("midrst press", int'(press_pulse), 1);
      btn_in = 1'b0;
      rst    = 1'b1;
      step();
      chk_all_zero("midrst in reset");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("midrst after c%0d release", i), int'(release_pulse), 0);
         chk($sformatf("midrst after c%0d press", i),   int'(press_pulse),   0);
      end
      exp_count = 8'd0;

      // 256 minimum-length presses wrap the press counter back to 0.
      for (int p = 0; p < 256; p++) begin
         run_press(1, 5);
         if (p == 254) chk("wrap pre count", int'(press_count), 255);
      end
      chk("wrap count", int'(press_count), 0);
      chk("pulse exclusivity violations", n_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
